instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the instruction-memory capacity in 32-bit words, a power of two and at least 2.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first word written.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  encoder accepts the command this cycle.
REQ-007 cmd_kind  in  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=j, 5=jal; 6 and 7 are illegal.
REQ-008 cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register and shift fields.
REQ-009 cmd_funct  in  6  R-type function field.
REQ-010 cmd_imm  in  16  immediate field for lw, sw and beq.
REQ-011 cmd_target  in  26  jump-target field for j and jal.
REQ-012 flush  in  1  clears the write pointer and count.
REQ-013 mem_we  out  1  write strobe to instruction memory.
REQ-014 mem_addr  out  32  byte address of the write.
REQ-015 mem_wdata  out  32  encoded instruction word.
REQ-016 count  out  clog2(DEPTH+1)  number of words written since reset or flush.
REQ-017 full  out  1  high when count equals DEPTH.
REQ-018 err  out  1  one-cycle pulse when an illegal cmd_kind is accepted.

Function
REQ-019 A handshake SHALL occur when cmd_valid and cmd_ready are both high at a rising edge.
REQ-020 cmd_ready SHALL equal !full && !flush && !rst, combinationally.
REQ-021 The encoder SHALL pack R-type as {6'b000000, rs, rt, rd, shamt, funct}.
REQ-022 The encoder SHALL pack lw, sw and beq as {opcode, rs, rt, imm}, with opcodes 100011, 101011 and 000100 respectively.
REQ-023 The encoder SHALL pack j and jal as {opcode, target}, with opcodes 000010 and 000011 respectively.
REQ-024 Fields not used by the selected kind SHALL be ignored.
REQ-025 A legal handshake at edge N SHALL produce mem_we=1 for exactly the cycle after edge N, together with the registered mem_wdata and mem_addr = BASE_ADDR + 4*wr_ptr.
REQ-026 Commands SHALL be accepted back-to-back at a throughput of one per cycle.
REQ-027 Each write SHALL increment wr_ptr and count by 1.
REQ-028 wr_ptr SHALL wrap from DEPTH-1 to 0; when count reaches DEPTH, full=1 and no further commands are accepted until flush.
REQ-029 An illegal-kind handshake SHALL consume the command, leave mem_we=0, leave wr_ptr and count unchanged, and pulse err=1 in the following cycle.
REQ-030 A flush at edge N SHALL set wr_ptr=0, count=0 and full=0.
REQ-031 A write already registered before edge N SHALL still be issued, at its original address, in the cycle after edge N, and SHALL NOT be counted.
REQ-032 cmd_valid asserted together with flush SHALL NOT be handshaken.
REQ-033 When mem_we=0, mem_wdata and mem_addr SHALL hold their last values.
REQ-034 The state machine SHALL have states IDLE (no write pending), WRITE (write pending this cycle) and FULL.
REQ-035 The state machine SHALL transition IDLE->WRITE on a legal handshake, WRITE->WRITE on a legal handshake, and WRITE->IDLE otherwise.
REQ-036 The state machine SHALL transition WRITE->FULL when the issuing write makes count equal DEPTH, and FULL->IDLE on flush.

Reset
REQ-037 rst SHALL force state=IDLE, wr_ptr=0, count=0, full=0, mem_we=0, err=0, mem_wdata=0 and mem_addr=BASE_ADDR at the next edge.
REQ-038 rst SHALL take priority over flush and over any handshake.
REQ-039 A write pending at reset SHALL be discarded.

Structure
REQ-040 Opcode constants and the cmd_kind encodings SHALL reside in a shared package, so that the instruction encoder and the opcode decoder use identical values.
REQ-041 Field packing SHALL be a combinational sub-module instr_pack, taking kind and fields and producing word and illegal; instr_encoder SHALL hold the state machine, pointer, count and output registers.

Verification
REQ-042 R-type, rs=8, rt=9, rd=10, shamt=0, funct=0x20 -> next cycle mem_we=1, mem_wdata=0x01095020, mem_addr=0x00000000.
REQ-043 Five consecutive cycles of handshakes of lw(16,8,4), sw(29,31,0), beq(1,2,0xFFFF), j(0x0000010), jal(0x0000010) -> mem_wdata = 0x8E080004, 0xAFBF0000, 0x1022FFFF, 0x08000010, 0x0C000010 at addresses 0x0 through 0x10 in consecutive cycles, ending with count=5.
REQ-044 With DEPTH=4, issue 4 writes and then hold cmd_valid high -> full=1, cmd_ready=0, no fifth write; then flush -> count=0, and the next write goes to address 0x0.
REQ-045 cmd_kind=6 handshake -> err=1 for one cycle, mem_we=0, count unchanged; the following legal command writes to the next unused address.
REQ-046 rst asserted in the cycle after a handshake -> no mem_we, count=0, all outputs at their reset values; flush together with cmd_valid -> command not accepted.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, command-kind encodings and state type for the
// instruction encoder and any matching opcode decoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_R   = 3'd0,
    KIND_LW  = 3'd1,
    KIND_SW  = 3'd2,
    KIND_BEQ = 3'd3,
    KIND_J   = 3'd4,
    KIND_JAL = 3'd5
  } cmd_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_e;

  // I-type layout shared by lw, sw and beq.
  function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command and instruction-memory write bus of the instruction encoder.
interface instr_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_kind;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_shamt;
  logic [5:0]  cmd_funct;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
           cmd_funct, cmd_imm, cmd_target,
    input  cmd_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
           cmd_funct, cmd_imm, cmd_target,
    output cmd_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational field packer: turns a command kind plus fields into a
// 32-bit instruction word and flags kinds that have no encoding.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the layout for the requested kind.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (kind)
      KIND_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:  word = pack_itype(OP_LW, rs, rt, imm);
      KIND_SW:  word = pack_itype(OP_SW, rs, rt, imm);
      KIND_BEQ: word = pack_itype(OP_BEQ, rs, rt, imm);
      KIND_J:   word = {OP_J, target};
      KIND_JAL: word = {OP_JAL, target};
      default: begin
        word    = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode commands, writes packed words to
// sequential instruction-memory addresses and tracks fill level.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  instr_encoder_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  enc_state_e       state_r;
  enc_state_e       state_next_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_inc_s;
  logic             full_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             err_r;
  logic [31:0]      pack_word_s;
  logic             pack_illegal_s;
  logic             hs_s;
  logic             legal_hs_s;

  instr_pack u_pack (
    .kind    (bus.cmd_kind),
    .rs      (bus.cmd_rs),
    .rt      (bus.cmd_rt),
    .rd      (bus.cmd_rd),
    .shamt   (bus.cmd_shamt),
    .funct   (bus.cmd_funct),
    .imm     (bus.cmd_imm),
    .target  (bus.cmd_target),
    .word    (pack_word_s),
    .illegal (pack_illegal_s)
  );

  // Ready deliberately drops in the flush and reset cycles so neither can race a handshake.
  assign bus.cmd_ready = !full_r && !flush && !rst;
  assign hs_s          = bus.cmd_valid && bus.cmd_ready;
  assign legal_hs_s    = hs_s && !pack_illegal_s;
  assign count_inc_s   = count_r + CNT_W'(1);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (legal_hs_s) state_next_s = ST_WRITE;
        else            state_next_s = ST_IDLE;
      end
      ST_WRITE: begin
        if (flush)           state_next_s = ST_IDLE;
        else if (legal_hs_s) state_next_s = ST_WRITE;
        else if (full_r)     state_next_s = ST_FULL;
        else                 state_next_s = ST_IDLE;
      end
      ST_FULL: begin
        if (flush) state_next_s = ST_IDLE;
        else       state_next_s = ST_FULL;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Pointer, fill count and registered write/err outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      err_r       <= 1'b0;
      mem_wdata_r <= 32'h0000_0000;
      mem_addr_r  <= BASE_ADDR;
    end else begin
      mem_we_r <= legal_hs_s;
      err_r    <= hs_s && pack_illegal_s;
      if (legal_hs_s) begin
        mem_wdata_r <= pack_word_s;
        mem_addr_r  <= BASE_ADDR + 32'({wr_ptr_r, 2'b00});
      end
      if (flush) begin
        wr_ptr_r <= '0;
        count_r  <= '0;
        full_r   <= 1'b0;
      end else if (legal_hs_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        count_r  <= count_inc_s;
        full_r   <= (count_inc_s == CNT_W'(DEPTH));
      end
    end
  end

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign count         = count_r;
  assign full          = full_r;
  assign err           = err_r;

endmodule
